// File: rtl/rom_stream_sequencer.sv
// rom_stream_sequencer: runs {base,len,rep} commands as ROM reads and streams the words out
// on AXI-Stream, using a 2-entry fall-through FIFO so words can be sent with full backpressure.
module rom_stream_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int REP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [REP_W-1:0]  cmd_rep,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              tvalid,
    input  logic              tready,
    output logic [DATA_W-1:0] tdata,
    output logic              tlast,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = LEN_W + REP_W + 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] base_q, addr_q, rom_addr_q;
    logic [LEN_W-1:0]  len_q, beat_q;
    logic [CNT_W-1:0]  total_q, issued_q, sent_q;
    logic              rom_en_q, rom_vld_q, done_q;
    logic [DATA_W-1:0] mem_q [2];
    logic              wp_q, rp_q;
    logic [1:0]        cnt_q, cnt_d;
    logic              accept, issue, pop, push, pop_buf, last_hs;
    logic [ADDR_W-1:0] cur_addr, cur_base;
    logic [LEN_W-1:0]  cur_len, cur_beat;
    logic [CNT_W-1:0]  cur_issued, cur_total, total_new;
    assign cmd_ready  = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign rom_en     = rom_en_q;
    assign rom_addr   = rom_addr_q;
    assign accept     = cmd_valid & cmd_ready;
    assign total_new  = CNT_W'((32'(cmd_len) + 1) * (32'(cmd_rep) + 1));
    // The accept cycle issues the first read itself, so operands come from the command bus then.
    assign cur_addr   = accept ? cmd_base : addr_q;
    assign cur_base   = accept ? cmd_base : base_q;
    assign cur_len    = accept ? cmd_len : len_q;
    assign cur_beat   = accept ? '0 : beat_q;
    assign cur_issued = accept ? '0 : issued_q;
    assign cur_total  = accept ? total_new : total_q;
    // Head is the buffered word if any, otherwise the ROM word arriving this cycle.
    assign tvalid  = (cnt_q != 2'd0) | rom_vld_q;
    assign tdata   = (cnt_q != 2'd0) ? mem_q[rp_q] : (rom_vld_q ? rom_data : '0);
    assign tlast   = tvalid & (sent_q == total_q - CNT_W'(1));
    assign pop     = tvalid & tready;
    assign pop_buf = pop & (cnt_q != 2'd0);
    assign push    = rom_vld_q & ~((cnt_q == 2'd0) & pop);
    assign last_hs = pop & tlast;
    assign cnt_d   = cnt_q + 2'(push) - 2'(pop_buf);
    // Buffered words plus the read about to land must leave a slot for a new read.
    assign issue   = (accept | (state_q == RUN)) & ({1'b0, cnt_d} + {2'b0, rom_en_q} < 3'd2);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            addr_q     <= '0;
            rom_addr_q <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            total_q    <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            rom_en_q   <= 1'b0;
            rom_vld_q  <= 1'b0;
            done_q     <= 1'b0;
            mem_q      <= '{default: '0};
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rom_en_q  <= issue;
            rom_vld_q <= rom_en_q;
            done_q    <= last_hs;
            cnt_q     <= cnt_d;
            if (accept) begin
                base_q  <= cmd_base;
                len_q   <= cmd_len;
                total_q <= total_new;
                sent_q  <= '0;
            end else if (pop) begin
                sent_q <= sent_q + CNT_W'(1);
            end
            if (issue) begin
                rom_addr_q <= cur_addr;
                addr_q     <= (cur_beat == cur_len) ? cur_base : cur_addr + ADDR_W'(1);
                beat_q     <= (cur_beat == cur_len) ? '0 : cur_beat + LEN_W'(1);
                issued_q   <= cur_issued + CNT_W'(1);
            end
            if (push) begin
                mem_q[wp_q] <= rom_data;
                wp_q        <= ~wp_q;
            end
            if (pop_buf) rp_q <= ~rp_q;
            case (state_q)
                IDLE:    state_q <= accept ? ((issue && cur_issued == cur_total - CNT_W'(1)) ? DRAIN : RUN) : IDLE;
                RUN:     state_q <= (issue && cur_issued == cur_total - CNT_W'(1)) ? DRAIN : RUN;
                DRAIN:   state_q <= last_hs ? IDLE : DRAIN;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_stream_sequencer.sv
// tb_rom_stream_sequencer: directed and random commands checked against a beat-list model
// built from the command fields.
module tb_rom_stream_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_base = '0;
    logic [7:0]  cmd_len = '0;
    logic [3:0]  cmd_rep = '0;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data = '0;
    logic        tvalid;
    logic        tready = 1'b1;
    logic [31:0] tdata;
    logic        tlast;
    logic        busy;
    logic        done;

    rom_stream_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_rep(cmd_rep),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .tvalid(tvalid), .tready(tready), .tdata(tdata), .tlast(tlast),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_data <= {24'hA5A5A5, rom_addr};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [32:0] sb[$];
    logic        busy_m = 1'b0, done_m = 1'b0, post_rst = 1'b0;
    logic        stall_p = 1'b0, p_last = 1'b0, acc_done = 1'b0;
    logic [31:0] p_data = '0;
    int          wait_m = 0, osd = 0, hsn = 0, acc_cnt = 0;
    logic        full_rate = 1'b0, rnd_mode = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            busy_m = 0; done_m = 0; wait_m = 0; osd = 0; stall_p = 0; post_rst = 1;
        end else begin
            if (post_rst) begin
                chk("rst_rom_en", rom_en, 0);
                chk("rst_rom_addr", rom_addr, 0);
                chk("rst_tvalid", tvalid, 0);
                chk("rst_tdata", tdata, 0);
                chk("rst_tlast", tlast, 0);
                post_rst = 0;
            end
            chk("busy", busy, busy_m);
            chk("cmd_ready", cmd_ready, !busy_m);
            chk("done", done, done_m);
            if (wait_m == 2) chk("lat_n1_tvalid", tvalid, 0);
            if (wait_m == 1) chk("lat_n2_tvalid", tvalid, 1);
            if (sb.size() == 0) chk("tvalid_no_data", tvalid, 0);
            if (full_rate && wait_m == 0 && sb.size() != 0) chk("no_bubble", tvalid, 1);
            if (stall_p) begin
                chk("stall_tvalid", tvalid, 1);
                chk("stall_tdata", tdata, p_data);
                chk("stall_tlast", tlast, p_last);
            end
            if (tvalid && sb.size() != 0) begin
                chk("tdata", tdata, sb[0][31:0]);
                chk("tlast", tlast, sb[0][32]);
            end
            if (rom_en) osd++;
            chk("outstanding_le2", osd <= 2, 1);
            done_m = 0;
            if (wait_m > 0) wait_m--;
            if (tvalid && tready) begin
                if (sb.size() == 0) chk("hs_unexpected", 1, 0);
                else if (sb.pop_front() >> 32 != 0) begin
                    busy_m = 0;
                    done_m = 1;
                end
                osd--;
                hsn++;
            end
            stall_p = tvalid && !tready;
            p_data = tdata;
            p_last = tlast;
            if (cmd_valid && cmd_ready) begin
                for (int p = 0; p <= int'(cmd_rep); p++)
                    for (int b = 0; b <= int'(cmd_len); b++) begin
                        logic [7:0] a;
                        a = cmd_base + 8'(b);
                        sb.push_back({(p == int'(cmd_rep) && b == int'(cmd_len)), 24'hA5A5A5, a});
                    end
                busy_m = 1;
                wait_m = 2;
                acc_done = done;
                acc_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) tready = $urandom_range(0, 3) != 0;
    endtask

    task automatic send_cmd(input logic [7:0] b, input logic [7:0] l, input logic [3:0] r);
        int a0, i;
        cmd_base = b; cmd_len = l; cmd_rep = r; cmd_valid = 1;
        a0 = acc_cnt;
        for (i = 0; i < 5000; i++) begin
            tick();
            if (acc_cnt != a0) break;
        end
        if (i == 5000) chk("cmd_timeout", 0, 1);
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 5000; i++) begin
            tick();
            if (!busy && sb.size() == 0) break;
        end
        if (i == 5000) chk("idle_timeout", 0, 1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, i;
        repeat (3) tick();
        reset = 0;
        tick();
        full_rate = 1;
        send_cmd(8'h10, 8'd3, 4'd0);
        wait_idle();
        send_cmd(8'h20, 8'd1, 4'd2);
        wait_idle();
        full_rate = 0;
        h0 = hsn;
        send_cmd(8'h00, 8'd7, 4'd0);
        for (i = 0; i < 200 && hsn - h0 < 3; i++) tick();
        tready = 0;
        repeat (5) tick();
        tready = 1;
        wait_idle();
        full_rate = 1;
        send_cmd(8'hFE, 8'd3, 4'd0);
        wait_idle();
        send_cmd(8'h30, 8'd3, 4'd0);
        send_cmd(8'h40, 8'd0, 4'd0);
        chk("b2b_accept_in_done", acc_done, 1);
        wait_idle();
        h0 = hsn;
        send_cmd(8'h80, 8'd15, 4'd0);
        for (i = 0; i < 200 && hsn - h0 < 3; i++) tick();
        reset = 1;
        tick();
        reset = 0;
        tick();
        send_cmd(8'h05, 8'd0, 4'd0);
        wait_idle();
        full_rate = 0;
        rnd_mode = 1;
        repeat (12) begin
            send_cmd(8'($urandom), 8'($urandom_range(0, 12)), 4'($urandom_range(0, 3)));
            wait_idle();
        end
        rnd_mode = 0;
        tready = 1;
        full_rate = 1;
        repeat (4) begin
            send_cmd(8'($urandom), 8'($urandom_range(0, 20)), 4'($urandom_range(0, 2)));
            wait_idle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
